// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU constants: op encodings, latencies, FSM states and the HI/LO pair type.
package mdu_ctrl_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_CYCLES = 5;
    localparam int unsigned DIV_CYCLES = 10;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // True for the multi-cycle arithmetic ops (MULT, MULTU, DIV, DIVU).
    function automatic logic is_arith(input op_e o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / 32-bit divide result generator for the MDU.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo,
    output logic            div_zero
);

    op_e               opc;
    logic              mul_sgn;
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] prod;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    assign opc = op_e'(op);

    // Sign/zero extension to 64 bits makes the low 64 product bits correct for both flavours.
    assign mul_sgn = (opc == OP_MULT);
    assign ext_a   = {{XLEN{mul_sgn & a[XLEN-1]}}, a};
    assign ext_b   = {{XLEN{mul_sgn & b[XLEN-1]}}, b};
    assign prod    = ext_a * ext_b;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign neg_a   = (opc == OP_DIV) & a[XLEN-1];
    assign neg_b   = (opc == OP_DIV) & b[XLEN-1];
    assign mag_a   = neg_a ? (XLEN'(0) - a) : a;
    assign mag_b   = neg_b ? (XLEN'(0) - b) : b;
    assign divisor = (mag_b == XLEN'(0)) ? XLEN'(1) : mag_b;
    assign quo     = mag_a / divisor;
    assign rem     = mag_a % divisor;
    assign quo_s   = (neg_a ^ neg_b) ? (XLEN'(0) - quo) : quo;
    assign rem_s   = neg_a ? (XLEN'(0) - rem) : rem;

    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        div_zero = 1'b0;
        case (opc)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[2*XLEN-1:XLEN];
                res_lo = prod[XLEN-1:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi   = rem_s;
                res_lo   = quo_s;
                div_zero = (b == XLEN'(0));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: accept FSM, latency counter, shadow and architectural HI/LO registers.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      op,
    input  logic            op_valid,
    input  logic            md_use,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            start,
    output logic            busy,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    op_e              opc;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    hilo_t            hilo_q, hilo_d;
    hilo_t            shd_q, shd_d;
    logic [XLEN-1:0]  res_hi;
    logic [XLEN-1:0]  res_lo;
    logic             div_zero;

    assign opc = op_e'(op);

    mdu_arith u_arith (
        .op       (op),
        .a        (a),
        .b        (b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign start = op_valid & is_arith(opc) & (state_q == IDLE);
    assign stall = md_use & (start | busy_q);
    assign busy  = busy_q;
    assign hi    = hilo_q.hi;
    assign lo    = hilo_q.lo;

    // Next-state and datapath updates; ops arriving outside IDLE fall through untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hilo_d  = hilo_q;
        shd_d   = shd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    // Divide by zero retires the current HI/LO so the architectural state is kept.
                    shd_d  = div_zero ? hilo_q : hilo_t'{hi: res_hi, lo: res_lo};
                    if ((opc == OP_MULT) || (opc == OP_MULTU)) begin
                        state_d = MUL_RUN;
                        cnt_d   = CNT_W'(MUL_CYCLES);
                    end else begin
                        state_d = DIV_RUN;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                    end
                end else if (op_valid && (opc == OP_MTHI)) begin
                    hilo_d.hi = a;
                end else if (op_valid && (opc == OP_MTLO)) begin
                    hilo_d.lo = a;
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    hilo_d  = shd_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hilo_q  <= '0;
            shd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hilo_q  <= hilo_d;
            shd_q   <= shd_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed-vector bench for mdu_ctrl with hand-computed HI/LO, busy and stall expectations.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic        op_valid;
    logic        md_use;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int vec  = 0;
    int errs = 0;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .op_valid (op_valid),
        .md_use   (md_use),
        .a        (a),
        .b        (b),
        .start    (start),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic v, input logic m,
                         input logic [31:0] aa, input logic [31:0] bb);
        op = o; op_valid = v; md_use = m; a = aa; b = bb;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        vec++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || start !== 1'b0 || stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h start=%b stall=%b required all zero",
                     busy, hi, lo, start, stall);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        drive(OP_MULT, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
        #1;
        vec++;
        if (start !== 1'b1 || stall !== 1'b0) begin
            errs++;
            $display("FAIL mult_start start=%b stall=%b required start=1 stall=0", start, stall);
        end
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (busy !== 1'b1 || start !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
                errs++;
                $display("FAIL mult_busy[%0d] busy=%b start=%b hi=%h lo=%h required busy=1 start=0 hi=0 lo=0",
                         i, busy, start, hi, lo);
            end
            tick();
        end
        vec++;
        if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errs++;
            $display("FAIL mult_result busy=%b hi=%h lo=%h required busy=0 hi=ffffffff lo=fffffffa",
                     busy, hi, lo);
        end
    endtask

    task automatic test_divu();
        drive(OP_DIVU, 1'b1, 1'b0, 32'd100, 32'd7);
        #1;
        vec++;
        if (start !== 1'b1) begin
            errs++;
            $display("FAIL divu_start start=%b required 1", start);
        end
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (busy !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
                errs++;
                $display("FAIL divu_busy[%0d] busy=%b hi=%h lo=%h required busy=1 hi=ffffffff lo=fffffffa",
                         i, busy, hi, lo);
            end
            tick();
        end
        vec++;
        if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
            errs++;
            $display("FAIL divu_result busy=%b hi=%h lo=%h required busy=0 hi=2 lo=e", busy, hi, lo);
        end
    endtask

    task automatic test_div_signed();
        // -7 / 2 -> quotient -3, remainder -1
        drive(OP_DIV, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (busy !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
                errs++;
                $display("FAIL divs_busy[%0d] busy=%b hi=%h lo=%h required busy=1 hi=2 lo=e", i, busy, hi, lo);
            end
            tick();
        end
        vec++;
        if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errs++;
            $display("FAIL divs_result hi=%h lo=%h required hi=ffffffff lo=fffffffd", hi, lo);
        end
        drive(OP_DIV, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) tick();
        vec++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errs++;
            $display("FAIL div_overflow busy=%b hi=%h lo=%h required busy=0 hi=0 lo=80000000", busy, hi, lo);
        end
    endtask

    task automatic test_mthi_divzero();
        drive(OP_MTHI, 1'b1, 1'b0, 32'hAAAA_5555, 32'h0);
        #1;
        vec++;
        if (start !== 1'b0) begin
            errs++;
            $display("FAIL mthi_start start=%b required 0", start);
        end
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++;
        if (busy !== 1'b0 || hi !== 32'hAAAA_5555 || lo !== 32'h8000_0000) begin
            errs++;
            $display("FAIL mthi_write busy=%b hi=%h lo=%h required busy=0 hi=aaaa5555 lo=80000000", busy, hi, lo);
        end
        drive(OP_DIV, 1'b1, 1'b0, 32'd5, 32'd0);
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (busy !== 1'b1) begin
                errs++;
                $display("FAIL divzero_busy[%0d] busy=%b required 1", i, busy);
            end
            tick();
        end
        vec++;
        if (busy !== 1'b0 || hi !== 32'hAAAA_5555 || lo !== 32'h8000_0000) begin
            errs++;
            $display("FAIL divzero_keep busy=%b hi=%h lo=%h required busy=0 hi=aaaa5555 lo=80000000", busy, hi, lo);
        end
    endtask

    task automatic test_multu_stall();
        drive(OP_MULTU, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        vec++;
        if (start !== 1'b1 || stall !== 1'b1) begin
            errs++;
            $display("FAIL multu_start start=%b stall=%b required start=1 stall=1", start, stall);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(OP_MTHI, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0);
            #1;
            vec++;
            if (stall !== 1'b1 || start !== 1'b0 || busy !== 1'b1 ||
                hi !== 32'hAAAA_5555 || lo !== 32'h8000_0000) begin
                errs++;
                $display("FAIL multu_busy[%0d] stall=%b start=%b busy=%b hi=%h lo=%h required stall=1 start=0 busy=1 hi=aaaa5555 lo=80000000",
                         i, stall, start, busy, hi, lo);
            end
            tick();
        end
        drive(OP_NOP, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        vec++;
        if (stall !== 1'b0 || busy !== 1'b0 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errs++;
            $display("FAIL multu_result stall=%b busy=%b hi=%h lo=%h required stall=0 busy=0 hi=fffffffe lo=00000001",
                     stall, busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        // -3 * 7 = -21, then DIVU 16 / 3 issued the cycle busy drops
        drive(OP_MULT, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7);
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) tick();
        drive(OP_DIVU, 1'b1, 1'b0, 32'd16, 32'd3);
        #1;
        vec++;
        if (start !== 1'b1 || busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errs++;
            $display("FAIL b2b_start start=%b busy=%b hi=%h lo=%h required start=1 busy=0 hi=ffffffff lo=ffffffeb",
                     start, busy, hi, lo);
        end
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (busy !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
                errs++;
                $display("FAIL b2b_busy[%0d] busy=%b hi=%h lo=%h required busy=1 hi=ffffffff lo=ffffffeb",
                         i, busy, hi, lo);
            end
            tick();
        end
        vec++;
        if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd5) begin
            errs++;
            $display("FAIL b2b_result busy=%b hi=%h lo=%h required busy=0 hi=1 lo=5", busy, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        drive(OP_DIV, 1'b1, 1'b0, 32'd100, 32'd3);
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        vec++;
        if (busy !== 1'b1 || hi !== 32'd1 || lo !== 32'd5) begin
            errs++;
            $display("FAIL rst_pre busy=%b hi=%h lo=%h required busy=1 hi=1 lo=5", busy, hi, lo);
        end
        #2;
        reset = 1'b0;
        #1;
        vec++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errs++;
            $display("FAIL rst_async busy=%b hi=%h lo=%h required all zero", busy, hi, lo);
        end
        tick();
        @(negedge clk);
        reset = 1'b1;
        drive(OP_MTLO, 1'b1, 1'b0, 32'h0000_1234, 32'h0);
        #1;
        vec++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL mtlo_start start=%b busy=%b required start=0 busy=0", start, busy);
        end
        tick();
        drive(OP_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        vec++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0000_1234) begin
            errs++;
            $display("FAIL mtlo_write busy=%b hi=%h lo=%h required busy=0 hi=0 lo=1234", busy, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_div_signed();
        test_mthi_divzero();
        test_multu_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL define constant MUL_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL define constant DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op  input  3  operation: NOP=000, MULT=001, MULTU=010, DIV=011, DIVU=100, MTHI=101, MTLO=110, 111 treated as NOP.
REQ-006 SHALL have port op_valid  input  1  op is valid in E stage this cycle.
REQ-007 SHALL have port md_use  input  1  instruction in D stage uses MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-008 SHALL have port a  input  32  rs operand, forwarded.
REQ-009 SHALL have port b  input  32  rt operand, forwarded.
REQ-010 SHALL have port start  output  1  combinational, high when an arithmetic op is accepted this cycle.
REQ-011 SHALL have port busy  output  1  registered, arithmetic op in progress.
REQ-012 SHALL have port stall  output  1  combinational, pipeline stall request to D stage.
REQ-013 SHALL have port hi  output  32  architectural HI.
REQ-014 SHALL have port lo  output  32  architectural LO.

Function
REQ-015 SHALL implement states IDLE, MUL_RUN, DIV_RUN.
REQ-016 start SHALL equal op_valid & (op in MULT..DIVU) & state==IDLE.
REQ-017 On start, SHALL latch result into shadow HI/LO, load counter with MUL_CYCLES or DIV_CYCLES, enter MUL_RUN or DIV_RUN.
REQ-018 busy SHALL be high exactly MUL_CYCLES/DIV_CYCLES cycles, starting the cycle after start.
REQ-019 Counter SHALL decrement each cycle in RUN; at count 1 the next edge SHALL copy shadow to hi/lo, clear busy, enter IDLE.
REQ-020 hi/lo SHALL stay at their old values throughout the busy window.
REQ-021 stall SHALL equal md_use & (start | busy).
REQ-022 MULT SHALL produce signed 64-bit a*b, MULTU unsigned; HI=bits[63:32], LO=bits[31:0].
REQ-023 DIV/DIVU SHALL give LO=quotient truncated toward zero, HI=remainder with dividend sign (signed/unsigned respectively).
REQ-024 DIV with a=0x80000000, b=0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-025 Divide by zero SHALL still run DIV_CYCLES with busy high, then leave hi/lo unchanged.
REQ-026 MTHI/MTLO with op_valid in IDLE SHALL write a into hi/lo at the next edge, no busy.
REQ-027 Any op_valid while state!=IDLE SHALL be ignored, no state, hi/lo or shadow change.
REQ-028 Back-to-back: op accepted in the cycle busy falls (state IDLE) SHALL start normally.

Reset
REQ-029 reset low SHALL immediately force state IDLE, counter 0, busy 0, hi 0, lo 0, shadow 0, regardless of operation in progress.
REQ-030 First op SHALL be accepted on the first rising edge with reset high.

Structure
REQ-031 Op encodings, MUL_CYCLES, DIV_CYCLES and state encodings SHALL live in a shared MDU constants header used by decoder and mdu_ctrl.
REQ-032 Combinational 64-bit mul/div result generation SHALL be sub-module mdu_arith (inputs op, a, b; outputs res_hi, res_lo, div_zero); mdu_ctrl holds FSM, counter and registers.

Verification
REQ-033 MULT a=0xFFFFFFFE(-2), b=3 -> start 1 cycle, busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 DIVU a=100, b=7 -> busy 10 cycles, then lo=14, hi=2; hi/lo unchanged during busy.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIV a=5, b=0 -> hi/lo keep prior values after 10 busy cycles.
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF with md_use=1 -> stall high 6 cycles (start+5 busy), hi=0xFFFFFFFE, lo=0x00000001; MTHI during busy ignored.
REQ-037 Reset low at cycle 3 of a DIV -> busy, hi, lo = 0 immediately; MTLO a=0x1234 after release -> lo=0x1234 next edge.
